// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register carrying pc/data/exc, with flush and a stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready; default is one entry.
module pipe_stage_reg #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              in_xfer;
  logic              out_xfer;
  logic              stalled;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] main_data;
  logic [EXC_W-1:0]  main_exc;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A flushed cycle's contents are discarded, so it is not counted as back-pressure.
  assign stalled = out_valid && !out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_pc   = main_pc;
  assign out_data = main_data;
  assign out_exc  = main_exc;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_ready_q;
  logic [PC_W-1:0]   main_pc_nxt;
  logic [DATA_W-1:0] main_data_nxt;
  logic [EXC_W-1:0]  main_exc_nxt;
  logic [PC_W-1:0]   skid_pc;
  logic [PC_W-1:0]   skid_pc_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_nxt;
  logic [EXC_W-1:0]  skid_exc;
  logic [EXC_W-1:0]  skid_exc_nxt;

  always_comb begin
    state_nxt     = state;
    main_pc_nxt   = main_pc;
    main_data_nxt = main_data;
    main_exc_nxt  = main_exc;
    skid_pc_nxt   = skid_pc;
    skid_data_nxt = skid_data;
    skid_exc_nxt  = skid_exc;
    if (flush) begin
      state_nxt     = EMPTY;
      main_pc_nxt   = '0;
      main_data_nxt = '0;
      main_exc_nxt  = '0;
      skid_pc_nxt   = '0;
      skid_data_nxt = '0;
      skid_exc_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt     = ONE;
            main_pc_nxt   = in_pc;
            main_data_nxt = in_data;
            main_exc_nxt  = in_exc;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_pc_nxt   = in_pc;
            main_data_nxt = in_data;
            main_exc_nxt  = in_exc;
          end else if (in_xfer) begin
            state_nxt     = TWO;
            skid_pc_nxt   = in_pc;
            skid_data_nxt = in_data;
            skid_exc_nxt  = in_exc;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain of main can happen.
          if (out_xfer) begin
            state_nxt     = ONE;
            main_pc_nxt   = skid_pc;
            main_data_nxt = skid_data;
            main_exc_nxt  = skid_exc;
            skid_pc_nxt   = '0;
            skid_data_nxt = '0;
            skid_exc_nxt  = '0;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_pc    <= '0;
      main_data  <= '0;
      main_exc   <= '0;
      skid_pc    <= '0;
      skid_data  <= '0;
      skid_exc   <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      main_pc    <= main_pc_nxt;
      main_data  <= main_data_nxt;
      main_exc   <= main_exc_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_data  <= skid_data_nxt;
      skid_exc   <= skid_exc_nxt;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);

`else

  logic valid_q;

  // Single entry: it can be refilled in the same cycle it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      main_pc   <= '0;
      main_data <= '0;
      main_exc  <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      main_pc   <= '0;
      main_data <= '0;
      main_exc  <= '0;
    end else if (in_xfer) begin
      valid_q   <= 1'b1;
      main_pc   <= in_pc;
      main_data <= in_data;
      main_exc  <= in_exc;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector tables, hand-written reset/saturation sequences, and
// randomized traffic against a queue-based reference model of pipe_stage_reg.
module tb_pipe_stage_reg;

  localparam int PC_W   = 64;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 16;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
  } entry_t;

  typedef struct {
    logic        do_rst;
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [63:0] pc;
    logic        ev;
    logic        eir;
    logic        chk_pc;
    logic [63:0] epc;
    int unsigned estall;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [EXC_W-1:0]  in_exc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic [CNT_W-1:0]  stall_cnt;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [7:0] s_in_pc = '0;
  logic [7:0] s_in_data = '0;
  logic [3:0] s_in_exc = '0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  logic [7:0] s_out_pc;
  logic [7:0] s_out_data;
  logic [3:0] s_out_exc;
  logic [3:0] s_stall_cnt;

  int checks = 0;
  int errors = 0;

  entry_t           q[$];
  logic             m_cleared;
  logic [CNT_W-1:0] m_stall;
  vec_t             vecs[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .out_exc(out_exc),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.PC_W(8), .DATA_W(8), .EXC_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pc(s_in_pc), .in_data(s_in_data), .in_exc(s_in_exc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_pc(s_out_pc), .out_data(s_out_data), .out_exc(s_out_exc),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Skid build holds up to two entries and in_ready reflects occupancy only.
  function automatic logic m_in_ready(input logic ordy);
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_cleared = 1'b1;
    m_stall   = '0;
  endtask

  task automatic check_output();
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, m_in_ready(out_ready)});
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_exc", 64'(out_exc), 64'(q[0].exc));
    end else if (m_cleared) begin
      check("out_pc_zero", out_pc, 64'd0);
      check("out_data_zero", 64'(out_data), 64'd0);
      check("out_exc_zero", 64'(out_exc), 64'd0);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply_stimulus(input logic iv, input logic ordy, input logic fl, input entry_t e);
    logic rdy;
    logic had;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_pc     = e.pc;
    in_data   = e.data;
    in_exc    = e.exc;
    #1;
    check_output();
    rdy = m_in_ready(ordy);
    had = (q.size() != 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_cleared = 1'b1;
    end else begin
      if (had && !ordy && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + 1;
      if (had && ordy) void'(q.pop_front());
      if (iv && rdy) begin
        q.push_back(e);
        m_cleared = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    rst         = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic do_rst, input logic iv, input logic ordy, input logic fl,
                              input logic [63:0] pc, input logic ev, input logic eir,
                              input logic chk_pc, input logic [63:0] epc, input int unsigned estall);
    vec_t v;
    v.do_rst = do_rst; v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
    v.ev = ev; v.eir = eir; v.chk_pc = chk_pc; v.epc = epc; v.estall = estall;
    return v;
  endfunction

  initial begin
    entry_t e;
    logic   ir_one;
`ifdef PIPE_SKID_EN
    ir_one = 1'b1;
`else
    ir_one = 1'b0;
`endif
    model_reset();

    // Streaming: back-to-back PCs, one-cycle latency, no gaps.
    vecs.push_back(mk(1, 1, 1, 0, 64'h1000, 0, 1, 0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 1, 0, 64'h1004, 1, 1, 1, 64'h1000, 0));
    vecs.push_back(mk(0, 1, 1, 0, 64'h1008, 1, 1, 1, 64'h1004, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    1, 1, 1, 64'h1008, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    0, 1, 0, 64'h0,    0));
`ifdef PIPE_SKID_EN
    // Back-pressure: two entries held, in_ready drops after the second accept.
    vecs.push_back(mk(1, 1, 1, 0, 64'hA000, 0, 1, 0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 0, 0, 64'hA004, 1, 1, 1, 64'hA000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'hA008, 1, 0, 1, 64'hA000, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'hA008, 1, 0, 1, 64'hA000, 2));
    vecs.push_back(mk(0, 1, 1, 0, 64'hA008, 1, 0, 1, 64'hA000, 3));
    vecs.push_back(mk(0, 1, 1, 0, 64'hA008, 1, 1, 1, 64'hA004, 3));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    1, 1, 1, 64'hA008, 3));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    0, 1, 0, 64'h0,    3));
`else
    // out_ready toggling: in_ready follows !out_valid || out_ready in the same cycle.
    vecs.push_back(mk(1, 1, 0, 0, 64'hB000, 0, 1, 0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 1, 0, 64'hB004, 1, 1, 1, 64'hB000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'hB008, 1, 0, 1, 64'hB004, 0));
    vecs.push_back(mk(0, 1, 1, 0, 64'hB008, 1, 1, 1, 64'hB004, 1));
    vecs.push_back(mk(0, 1, 0, 0, 64'hB00C, 1, 0, 1, 64'hB008, 1));
    vecs.push_back(mk(0, 1, 1, 0, 64'hB00C, 1, 1, 1, 64'hB008, 2));
    vecs.push_back(mk(0, 0, 0, 0, 64'h0,    1, 0, 1, 64'hB00C, 2));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    1, 1, 1, 64'hB00C, 3));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    0, 1, 0, 64'h0,    3));
`endif
    // Flush with a full stage and a new entry offered: nothing survives, counter kept.
    vecs.push_back(mk(1, 1, 0, 0, 64'hC000, 0, 1,      0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 0, 0, 64'hC004, 1, ir_one, 1, 64'hC000, 0));
    vecs.push_back(mk(0, 1, 0, 1, 64'h2000, 1, 0,      1, 64'hC000, 1));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    0, 1,      1, 64'h0,    1));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    0, 1,      1, 64'h0,    1));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0,    0, 1,      1, 64'h0,    1));

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      in_pc     = vecs[i].pc;
      in_data   = 32'h0;
      in_exc    = 16'h0;
      #1;
      check($sformatf("vec%0d.out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ev});
      check($sformatf("vec%0d.in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].eir});
      check($sformatf("vec%0d.stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].estall));
      if (vecs[i].chk_pc) check($sformatf("vec%0d.out_pc", i), out_pc, vecs[i].epc);
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset with entries held and stall counted, then first transfer after release.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 64'hABC;
    @(posedge clk); @(negedge clk);
    in_pc = 64'hDEF;
    @(posedge clk); @(negedge clk);
    check("pre_rst.out_valid", {63'd0, out_valid}, 64'd1);
    check("pre_rst.stall_cnt", 64'(stall_cnt), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst.out_pc", out_pc, 64'd0);
    check("async_rst.stall_cnt", 64'(stall_cnt), 64'd0);
    check("async_rst.in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 64'h3000;
    #1;
    check("post_rst.out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("post_rst.first_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst.first_pc", out_pc, 64'h3000);
    @(posedge clk); @(negedge clk);
    check("post_rst.drained", {63'd0, out_valid}, 64'd0);

    // Saturation on the 4-bit counter instance.
    do_reset();
    s_in_valid = 1'b1; s_in_pc = 8'h5A; s_out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      #1;
      check($sformatf("sat.stall_cnt@%0d", k), 64'(s_stall_cnt), 64'((k > 15) ? 15 : k));
      @(posedge clk); @(negedge clk);
    end
    check("sat.out_pc_held", 64'(s_out_pc), 64'h5A);
    s_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("sat.drained", {63'd0, s_out_valid}, 64'd0);
    check("sat.stall_kept", 64'(s_stall_cnt), 64'hF);

    // Sustained throughput then randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      e.pc = 64'h4000 + 64'(4 * k); e.data = $urandom; e.exc = 16'($urandom);
      apply_stimulus(1'b1, 1'b1, 1'b0, e);
    end
    for (int k = 0; k < 800; k++) begin
      e.pc   = {$urandom, $urandom};
      e.data = $urandom;
      e.exc  = 16'($urandom);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 31) == 0, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PC_W, default 64: program-counter field width.
REQ-002 Parameter DATA_W, default 32: instruction/payload field width.
REQ-003 Parameter EXC_W, default 16: exception-code field width.
REQ-004 Parameter CNT_W, default 32: stall-counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  synchronous discard of all held entries.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage accepts entry this cycle.
REQ-010 in_pc / in_data / in_exc  in  PC_W / DATA_W / EXC_W  upstream payload.
REQ-011 out_valid  out  1  downstream entry present.
REQ-012 out_ready  in  1  downstream accepts entry this cycle.
REQ-013 out_pc / out_data / out_exc  out  PC_W / DATA_W / EXC_W  downstream payload.
REQ-014 stall_cnt  out  CNT_W  count of back-pressured cycles.

Function
REQ-015 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready; both evaluated at the same edge.
REQ-016 Latency exactly 1 cycle: entry accepted at edge N appears on out_* after edge N when the stage was empty.
REQ-017 Entries leave in acceptance order; none duplicated or dropped except by flush.
REQ-018 While out_valid && !out_ready, out_pc/out_data/out_exc and out_valid hold stable.
REQ-019 Payload fields pass through unmodified, bit-exact at parameterised widths.
REQ-020 flush has priority over all transfers: next cycle out_valid=0, all entries invalid, held payload cleared to 0, in_ready=1; an in_valid in the flush cycle is discarded.
REQ-021 stall_cnt increments by 1 each cycle with out_valid && !out_ready; saturates at all-ones; flush does not clear it.
REQ-022 With PIPE_SKID_EN: two entries (main, skid); states EMPTY, ONE, TWO.
REQ-023 EMPTY: in-transfer -> ONE.
REQ-024 ONE: in and out transfer -> ONE (new entry to main); in only -> TWO (new entry to skid); out only -> EMPTY.
REQ-025 TWO: out-transfer -> ONE, skid moves to main; in_valid ignored since in_ready=0.
REQ-026 in_ready is a register output, 1 in EMPTY/ONE, 0 in TWO; no combinational path out_ready -> in_ready.
REQ-027 Sustained in_valid=1, out_ready=1 yields one transfer per cycle.

Reset
REQ-028 rst low asynchronously forces out_valid=0, out_pc=0, out_data=0, out_exc=0, stall_cnt=0, state EMPTY, skid entry cleared.
REQ-029 in_ready=1 during and after reset; reset mid-transfer drops both held entries.
REQ-030 Reset release is synchronous to clk; first transfer possible at first rising edge after release.

Configuration
REQ-031 Macro PIPE_SKID_EN defined: skid buffer and registered in_ready per REQ-022..027.
REQ-032 PIPE_SKID_EN undefined: single entry, in_ready = !out_valid || out_ready (combinational), full throughput, no skid storage; all other requirements unchanged.

Verification
REQ-033 Reset: rst low with out_valid=1 mid-cycle -> out_valid=0, out_pc=0, stall_cnt=0 immediately, before next edge.
REQ-034 Streaming: in_pc 0x1000,0x1004,0x1008 back-to-back, out_ready=1 -> same PCs on out_pc in order, one cycle later, no gaps.
REQ-035 Back-pressure (skid): out_ready=0 for 3 cycles, in_valid=1 -> two entries held, in_ready=0 after 2nd accept, stall_cnt=3, no loss on release.
REQ-036 Flush: TWO state, flush=1 with in_valid=1 in_pc=0x2000 -> out_valid=0 next cycle, 0x2000 never emitted, stall_cnt unchanged.
REQ-037 Saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt stops at 0xF.
REQ-038 Non-skid build: out_ready toggles each cycle -> in_ready equals !out_valid || out_ready same cycle, order preserved.
